// File: rtl/ascensor_pkg.sv
// Shared elevator definitions: button count and the bit position of every
// call button in the 10-bit button vectors.
package ascensor_pkg;

  localparam int N_BOTONES = 10;

  // Landing calls (floor, direction) followed by the in-car floor buttons.
  localparam int BTN_P1_ARRIBA   = 0;
  localparam int BTN_P2_ARRIBA   = 1;
  localparam int BTN_P2_ABAJO    = 2;
  localparam int BTN_P3_ARRIBA   = 3;
  localparam int BTN_P3_ABAJO    = 4;
  localparam int BTN_P4_ABAJO    = 5;
  localparam int BTN_P1_ASCENSOR = 6;
  localparam int BTN_P2_ASCENSOR = 7;
  localparam int BTN_P3_ASCENSOR = 8;
  localparam int BTN_P4_ASCENSOR = 9;

endpackage

// File: rtl/antirrebote.sv
// One button channel: 2-flop synchronizer, debounce counter and, when
// ATASCO_DETECT_EN is defined, a saturating stuck-press counter.
// 'sube' is a combinational strobe that is high during the cycle whose
// closing edge will raise 'estable'; the top registers it into a pulse.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic estable,
  output logic sube,
  output logic atascado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          estable_q;
  logic          distinto;
  logic          llega;
  logic          estable_next;

  // Two-flop synchronizer for the asynchronous contact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // The count is only meaningful while the synchronized level disagrees
  // with the accepted one; the edge that would reach DEBOUNCE_CYCLES flips.
  always_comb begin
    distinto     = sync_2 ^ estable_q;
    llega        = distinto && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    estable_next = llega ? ~estable_q : estable_q;
    sube         = llega && !estable_q;
  end

  // Debounce counter: any agreeing sample restarts the count, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      estable_q <= 1'b0;
    end else if (!distinto) begin
      cnt <= '0;
    end else if (llega) begin
      cnt       <= '0;
      estable_q <= ~estable_q;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign estable = estable_q;

`ifdef ATASCO_DETECT_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic [SW-1:0] cnt_atasco;
  logic          atasco_q;

  // Count cycles spent pressed (saturating); the flag drops on the very
  // edge the debounced level falls, so it keys off the next-state value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_atasco <= '0;
      atasco_q   <= 1'b0;
    end else if (!estable_next) begin
      cnt_atasco <= '0;
      atasco_q   <= 1'b0;
    end else if (estable_q) begin
      if (cnt_atasco != SW'(STUCK_CYCLES))
        cnt_atasco <= cnt_atasco + SW'(1);
      if (cnt_atasco == SW'(STUCK_CYCLES - 1))
        atasco_q <= 1'b1;
    end
  end

  assign atascado = atasco_q;
`else
  // Stuck detection compiled out: the flag folds to a constant 0 (the
  // parameter is legal only when non-negative, so the compare is false).
  assign atascado = (STUCK_CYCLES < 0);
`endif

endmodule

// File: rtl/acondicionador_botones.sv
// Button conditioner for the elevator call panel: debounces the 10 raw
// contacts and issues a one-cycle press pulse per accepted press.
// Optional stuck-button detection is enabled by defining ATASCO_DETECT_EN.
module acondicionador_botones
  import ascensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BOTONES-1:0] botones_raw,
  input  logic                 inhibir,
  output logic [N_BOTONES-1:0] botones,
  output logic [N_BOTONES-1:0] estables,
  output logic [N_BOTONES-1:0] atascados
);

  logic [N_BOTONES-1:0] sube;

  for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_antirrebote (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (botones_raw[i]),
      .estable (estables[i]),
      .sube    (sube[i]),
      .atascado(atascados[i])
    );
  end

  // Press pulse lands on the same edge the debounced level rises; an
  // inhibited press is dropped for good rather than deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      botones <= '0;
    end else begin
      botones <= sube & {N_BOTONES{~inhibir}};
    end
  end

endmodule
